// File: rtl/types_pkg.sv
// Shared types for the fetch stage.
//   word_t        : 32-bit machine word (addresses and instructions)
//   fetch_state_t : fetch control states (RUN, KILL, HALTED)
//   ibuf_entry_t  : one instruction-buffer slot, instruction plus its PC
package types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    KILL,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } ibuf_entry_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_ibuf.sv
// Circular FIFO holding fetched instructions together with their PCs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : write one entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   flush       : discard every entry; wins over push and pop
//   rdata       : head entry, show-ahead (valid whenever !empty)
//   count       : number of stored entries
//   full, empty : occupancy flags
module fetch_ibuf
  import types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  ibuf_entry_t             wdata,
  output ibuf_entry_t             rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  ibuf_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one-outstanding word reads to instruction
// memory, buffers returned instructions with their PCs and presents the head
// to decode. Handles redirects (branch/jump) and a permanent halt.
// Ports:
//   CLK, nRST                  : clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    : instruction memory read handshake
//   redirect_valid/redirect_pc : resolved control-flow target
//   halt                       : decode saw halt, stop fetching
//   instr_valid/instr/instr_pc : head of the instruction buffer
//   instr_ready                : decode consumes the head this cycle
//   halted                     : fetch permanently stopped
module fetch_stage
  import types_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    IBUF_DEPTH = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  output logic  imem_req,
  output word_t imem_addr,
  input  logic  imem_ack,
  input  word_t imem_rdata,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  input  logic  halt,
  output logic  instr_valid,
  output word_t instr,
  output word_t instr_pc,
  input  logic  instr_ready,
  output logic  halted
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(IBUF_DEPTH);

  fetch_state_t  state;
  word_t         pc;
  word_t         req_addr;
  logic          pending;
  logic          halt_req;
  logic          accepted;
  logic          stalled;
  logic          ibuf_push;
  logic          ibuf_pop;
  logic          ibuf_flush;
  logic          ibuf_full;
  logic          ibuf_empty;
  logic [CW-1:0] ibuf_count;
  ibuf_entry_t   ibuf_head;
  ibuf_entry_t   ibuf_wdata;

  // A request that was not acked stays up with its original address, so the
  // memory sees a stable request even if pc moves or the buffer fills.
  assign imem_req  = nRST & (pending | ((state == RUN) & (ibuf_count < DEPTH_COUNT)));
  assign imem_addr = pending ? req_addr : pc;

  // Acks are only meaningful against a live request; stray acks are ignored.
  assign accepted = imem_req & imem_ack;
  assign stalled  = imem_req & ~imem_ack;

  assign ibuf_flush = (state != HALTED) & (halt | redirect_valid);
  assign ibuf_push  = (state == RUN) & accepted & ~halt & ~redirect_valid & ~ibuf_full;
  assign ibuf_pop   = instr_valid & instr_ready;
  assign ibuf_wdata = '{pc: pc, instr: imem_rdata};

  assign instr_valid = ~ibuf_empty;
  assign instr       = ibuf_head.instr;
  assign instr_pc    = ibuf_head.pc;
  assign halted      = (state == HALTED);

  fetch_ibuf #(
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (ibuf_push),
    .pop   (ibuf_pop),
    .flush (ibuf_flush),
    .wdata (ibuf_wdata),
    .rdata (ibuf_head),
    .count (ibuf_count),
    .full  (ibuf_full),
    .empty (ibuf_empty)
  );

  // KILL waits out a request made before a redirect/halt and throws its data
  // away; halt_req remembers that the wait ends in HALTED rather than RUN.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      pending  <= 1'b0;
      halt_req <= 1'b0;
    end else begin
      pending  <= stalled;
      req_addr <= imem_addr;
      unique case (state)
        RUN: begin
          if (halt) begin
            if (stalled) begin
              state    <= KILL;
              halt_req <= 1'b1;
            end else begin
              state <= HALTED;
            end
          end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (stalled) state <= KILL;
          end else if (accepted) begin
            pc <= pc + PC_STEP;
          end
        end
        KILL: begin
          if (halt) begin
            halt_req <= 1'b1;
          end else if (redirect_valid && !halt_req) begin
            pc <= redirect_pc;
          end
          if (accepted) state <= (halt || halt_req) ? HALTED : RUN;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Instruction memory returns addr ^ KEY,
// so every expected instruction is derived from the expected address.
// A second instance checks a RESET_PC near the top of the address space.
module tb_fetch_stage;
  import types_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic  CLK;
  logic  nRST;
  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  halt;
  logic  instr_valid;
  word_t instr;
  word_t instr_pc;
  logic  instr_ready;
  logic  halted;

  logic  b_nrst;
  logic  b_req;
  word_t b_addr;
  logic  b_ack;
  word_t b_rdata;
  logic  b_valid;
  word_t b_instr;
  word_t b_instr_pc;
  logic  b_ready;
  logic  b_halted;

  int num_checks = 0;
  int num_passed = 0;

  assign imem_rdata = imem_addr ^ KEY;
  assign b_rdata    = b_addr ^ KEY;

  fetch_stage dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halted         (halted)
  );

  fetch_stage #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_top (
    .CLK            (CLK),
    .nRST           (b_nrst),
    .imem_req       (b_req),
    .imem_addr      (b_addr),
    .imem_ack       (b_ack),
    .imem_rdata     (b_rdata),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .halt           (1'b0),
    .instr_valid    (b_valid),
    .instr          (b_instr),
    .instr_pc       (b_instr_pc),
    .instr_ready    (b_ready),
    .halted         (b_halted)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Every comparison funnels through here so counting stays in one place.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got === exp) num_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs change at the falling edge, one rising edge passes, and the caller
  // samples at the following falling edge.
  task automatic applyStimulus(input logic ack, input logic ready, input logic redir,
                               input logic [31:0] rpc, input logic hlt);
    imem_ack       = ack;
    instr_ready    = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    halt           = hlt;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Holds reset for two cycles with quiet inputs, then releases it.
  task automatic resetDut();
    nRST           = 1'b0;
    imem_ack       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
  endtask

  // Directed scenarios, each starting from a fresh reset.
  initial begin
    b_nrst  = 1'b0;
    b_ack   = 1'b0;
    b_ready = 1'b0;
    nRST           = 1'b0;
    imem_ack       = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    $display("[TB] reset state and streaming fetch");
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_halted", halted, 0);
    resetDut();
    checkOutput("a_first_req", imem_req, 1);
    checkOutput("a_first_addr", imem_addr, 32'h0);
    checkOutput("a_first_valid", instr_valid, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput($sformatf("a_addr%0d", i), imem_addr, 32'(4 * (i + 1)));
      checkOutput($sformatf("a_valid%0d", i), instr_valid, 1);
      checkOutput($sformatf("a_pc%0d", i), instr_pc, 32'(4 * i));
      checkOutput($sformatf("a_instr%0d", i), instr, 32'(4 * i) ^ KEY);
    end
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("a_drain_valid", instr_valid, 0);
    checkOutput("a_hold_req", imem_req, 1);
    checkOutput("a_hold_addr", imem_addr, 32'h18);

    $display("[TB] buffer full backpressure");
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("b_full_req", imem_req, 0);
    checkOutput("b_full_pc", instr_pc, 32'h0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("b_stray_ack_req", imem_req, 0);
    checkOutput("b_stray_ack_pc", instr_pc, 32'h0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("b_resume_req", imem_req, 1);
    checkOutput("b_resume_addr", imem_addr, 32'h10);
    checkOutput("b_pop1_pc", instr_pc, 32'h4);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("b_pop2_pc", instr_pc, 32'h8);
    checkOutput("b_held_addr", imem_addr, 32'h10);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("b_pop3_pc", instr_pc, 32'hC);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("b_empty_valid", instr_valid, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("b_next_pc", instr_pc, 32'h10);
    checkOutput("b_next_instr", instr, 32'h10 ^ KEY);
    checkOutput("b_next_addr", imem_addr, 32'h14);

    $display("[TB] redirect while request outstanding");
    resetDut();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("c_pre_addr", imem_addr, 32'h8);
    applyStimulus(0, 0, 1, 32'h100, 0);
    checkOutput("c_kill_valid", instr_valid, 0);
    checkOutput("c_kill_req", imem_req, 1);
    checkOutput("c_kill_addr0", imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("c_kill_addr1", imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("c_kill_addr2", imem_addr, 32'h8);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("c_discard_valid", instr_valid, 0);
    checkOutput("c_target_addr", imem_addr, 32'h100);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("c_target_valid", instr_valid, 1);
    checkOutput("c_target_pc", instr_pc, 32'h100);
    checkOutput("c_target_instr", instr, 32'h100 ^ KEY);
    applyStimulus(0, 0, 1, 32'h300, 0);
    checkOutput("c2_kill_addr0", imem_addr, 32'h104);
    applyStimulus(0, 0, 1, 32'h380, 0);
    checkOutput("c2_kill_addr1", imem_addr, 32'h104);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("c2_latest_addr", imem_addr, 32'h380);
    checkOutput("c2_valid", instr_valid, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("c2_latest_pc", instr_pc, 32'h380);

    $display("[TB] redirect coincident with ack");
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("d_head_pc", instr_pc, 32'h8);
    checkOutput("d_req_addr", imem_addr, 32'hC);
    applyStimulus(1, 0, 1, 32'h40, 0);
    checkOutput("d_flush_valid", instr_valid, 0);
    checkOutput("d_target_addr", imem_addr, 32'h40);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("d_target_pc", instr_pc, 32'h40);
    checkOutput("d_after_addr", imem_addr, 32'h44);

    $display("[TB] halt with redirect and pending request");
    resetDut();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("e_pre_valid", instr_valid, 1);
    applyStimulus(0, 0, 1, 32'h500, 1);
    checkOutput("e_wait_req", imem_req, 1);
    checkOutput("e_wait_addr", imem_addr, 32'h4);
    checkOutput("e_wait_valid", instr_valid, 0);
    checkOutput("e_wait_halted", halted, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("e_wait2_addr", imem_addr, 32'h4);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("e_halted", halted, 1);
    checkOutput("e_halt_req", imem_req, 0);
    checkOutput("e_halt_valid", instr_valid, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, 32'h600, 0);
      checkOutput($sformatf("e_stay_halted%0d", i), halted, 1);
      checkOutput($sformatf("e_stay_req%0d", i), imem_req, 0);
      checkOutput($sformatf("e_stay_valid%0d", i), instr_valid, 0);
    end

    $display("[TB] address wrap from high RESET_PC");
    b_ack   = 1'b1;
    b_ready = 1'b1;
    b_nrst  = 1'b1;
    #1;
    checkOutput("f_addr0", b_addr, 32'hFFFF_FFF8);
    checkOutput("f_req0", b_req, 1);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("f_addr1", b_addr, 32'hFFFF_FFFC);
    checkOutput("f_pc1", b_instr_pc, 32'hFFFF_FFF8);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("f_addr2", b_addr, 32'h0000_0000);
    checkOutput("f_pc2", b_instr_pc, 32'hFFFF_FFFC);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("f_addr3", b_addr, 32'h0000_0004);
    checkOutput("f_pc3", b_instr_pc, 32'h0000_0000);
    checkOutput("f_instr3", b_instr, 32'h0000_0000 ^ KEY);
    checkOutput("f_halted", b_halted, 0);
    checkOutput("f_valid", b_valid, 1);

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter IBUF_DEPTH, default 4, meaning instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction memory read request.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address (word_t).
REQ-007 SHALL have port imem_ack  input  1  memory completes request this cycle.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 SHALL have port redirect_valid  input  1  resolved branch/jal/jalr taken.
REQ-010 SHALL have port redirect_pc  input  32  target, valid with redirect_valid.
REQ-011 SHALL have port halt  input  1  decode saw halt; stop fetching.
REQ-012 SHALL have port instr_valid  output  1  buffer head holds an instruction for decode.
REQ-013 SHALL have port instr  output  32  head instruction, feeds control unit instr.
REQ-014 SHALL have port instr_pc  output  32  PC of head instruction.
REQ-015 SHALL have port instr_ready  input  1  decode consumes head this cycle.
REQ-016 SHALL have port halted  output  1  fetch permanently stopped.

Function
REQ-017 SHALL implement FSM states RUN, KILL, HALTED (fetch_state_t).
REQ-018 RUN: imem_req=1 when buffer count < IBUF_DEPTH; imem_addr=pc.
REQ-019 Once asserted, imem_req and imem_addr SHALL hold stable until imem_ack, irrespective of buffer occupancy.
REQ-020 RUN, imem_ack=1, no redirect/halt: push {pc, imem_rdata}; pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-021 instr/instr_pc/instr_valid SHALL be driven combinationally from buffer head (show-ahead); ack in cycle N -> instr_valid=1 in N+1.
REQ-022 instr_valid & instr_ready SHALL pop head; push and pop in same cycle keep count unchanged.
REQ-023 redirect_valid=1: flush buffer, pc <= redirect_pc same edge; instr_valid=0 next cycle.
REQ-024 Redirect with request outstanding and imem_ack=0: go KILL; keep old request until ack; discard its data; then RUN fetching redirect_pc.
REQ-025 Redirect with imem_ack=1 same cycle: discard returned data, stay RUN, next request at redirect_pc.
REQ-026 KILL receiving a further redirect SHALL update pc to latest redirect_pc and remain in KILL.
REQ-027 halt=1 SHALL take priority over redirect_valid: flush buffer, no new requests.
REQ-028 halt with outstanding request: finish it (data discarded), then HALTED; otherwise HALTED next edge.
REQ-029 HALTED: imem_req=0, instr_valid=0, halted=1; exit only via reset.
REQ-030 No instruction SHALL be duplicated, dropped (absent flush) or reordered.

Reset
REQ-031 nRST=0 SHALL asynchronously force: state=RUN, pc=RESET_PC, buffer empty, halted=0, instr_valid=0, no request outstanding.
REQ-032 imem_req SHALL be 0 while nRST=0; first request at RESET_PC in first cycle after release.
REQ-033 Reset mid-request SHALL abandon it; late ack after reset with no outstanding request SHALL be ignored.

Structure
REQ-034 fetch_state_t and IBUF entry struct {word_t pc; word_t instr;} SHALL live in types_pkg.
REQ-035 Buffer SHALL be sub-module fetch_ibuf (circular FIFO, push/pop/flush, count, full/empty).
REQ-036 Outputs SHALL contain no combinational path from imem_rdata to instr.

Verification
REQ-037 Reset release, ack every cycle, instr_ready=1 -> addrs 0,4,8,...; instr_valid from cycle 2; instr_pc matches.
REQ-038 instr_ready=0, ack every cycle -> 4 pushes, imem_req=0 with count=4; one pop -> request at 0x10 resumes.
REQ-039 Redirect to 0x100 while request 0x8 pending (ack 3 cycles later) -> KILL, 0x8 data discarded, next imem_addr=0x100, first instr_pc=0x100.
REQ-040 Redirect to 0x40 coincident with ack for 0xC -> 0xC not delivered, next addr 0x40.
REQ-041 halt and redirect together with request pending -> request completes, halted=1, imem_req=0, instr_valid=0 forever.
REQ-042 RESET_PC=32'hFFFF_FFF8 -> fetch FFFF_FFF8, FFFF_FFFC, 0000_0000.
